// File: rtl/bpsk_pkg.sv
// Shared types and width helpers for the BPSK packet assembler.
// Optional checksum byte is enabled by defining PKT_CHECKSUM_EN.
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2
    } pkt_state_t;

    localparam int DROP_CNT_W = 16;

    // Index width for a counter over n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_byte_serializer.sv
// Read side: walks full banks byte-by-byte onto a valid/ready stream.
// PKT_CHECKSUM_EN appends an XOR checksum byte after each packet.
module pkt_byte_serializer
    import bpsk_pkg::*;
#(
    parameter int PACKET_BITS = 64,
    parameter int BYTE_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [1:0]                  bank_full,
    input  logic [1:0]                  bank_fill,
    input  logic [1:0][PACKET_BITS-1:0] bank_data,
    output logic [1:0]                  bank_free,
    output logic                        byte_valid,
    output logic [BYTE_W-1:0]           byte_data,
    input  logic                        byte_ready,
    output logic                        byte_last,
    output logic                        pkt_busy
);

    localparam int NBYTES = PACKET_BITS / BYTE_W;
    localparam int PTR_W  = idx_w(NBYTES);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NBYTES - 1);

    pkt_state_t        state;
    logic              rd_bank;
    logic [PTR_W-1:0]  ptr;
    logic [BYTE_W-1:0] data_byte;
    logic              hs;
    logic              last_data;
    logic              done;
    logic              other_full;

    assign data_byte  = bank_data[rd_bank][ptr*BYTE_W +: BYTE_W];
    assign hs         = byte_valid && byte_ready;
    assign last_data  = (state == SEND) && (ptr == LAST_PTR);
    // A bank being filled this very cycle counts, so packets chain with no gap.
    assign other_full = bank_full[~rd_bank] | bank_fill[~rd_bank];

    assign byte_valid = (state != IDLE);
    assign pkt_busy   = (state != IDLE);
    assign bank_free  = done ? (2'b01 << rd_bank) : 2'b00;

`ifdef PKT_CHECKSUM_EN
    logic [BYTE_W-1:0] acc;

    assign done      = hs && (state == CHK);
    assign byte_last = (state == CHK);

    always_comb begin
        byte_data = '0;
        if (state == SEND)
            byte_data = data_byte;
        else if (state == CHK)
            byte_data = acc;
    end
`else
    assign done      = hs && last_data;
    assign byte_last = last_data;

    always_comb begin
        byte_data = '0;
        if (state == SEND)
            byte_data = data_byte;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            ptr     <= '0;
`ifdef PKT_CHECKSUM_EN
            acc     <= '0;
`endif
        end else if (clear) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            ptr     <= '0;
`ifdef PKT_CHECKSUM_EN
            acc     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state <= SEND;
                        ptr   <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
`ifdef PKT_CHECKSUM_EN
                        acc <= acc ^ data_byte;
`endif
                        if (ptr == LAST_PTR) begin
                            ptr <= '0;
`ifdef PKT_CHECKSUM_EN
                            state <= CHK;
`else
                            rd_bank <= ~rd_bank;
                            state   <= other_full ? SEND : IDLE;
`endif
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
`ifdef PKT_CHECKSUM_EN
                CHK: begin
                    if (hs) begin
                        acc     <= '0;
                        rd_bank <= ~rd_bank;
                        state   <= other_full ? SEND : IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bpsk_packet_assembler.sv
// Ping-pong bit collector feeding a byte serializer toward the UART.
// Define PKT_CHECKSUM_EN to append an XOR checksum byte per packet.
module bpsk_packet_assembler
    import bpsk_pkg::*;
#(
    parameter int PACKET_BITS = 64,
    parameter int BYTE_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    input  logic                  clear,
    output logic                  byte_valid,
    output logic [BYTE_W-1:0]     byte_data,
    input  logic                  byte_ready,
    output logic                  byte_last,
    output logic                  pkt_busy,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int IDX_W = idx_w(PACKET_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BITS - 1);

    logic [1:0][PACKET_BITS-1:0] bank;
    logic [1:0]                  full;
    logic [1:0]                  fill;
    logic [1:0]                  bank_free;
    logic                        wr_bank;
    logic [IDX_W-1:0]            wr_idx;
    logic                        accept;
    logic                        drop;

    // A bank freed this cycle is still full here, so a colliding bit drops.
    assign accept = bit_valid && !full[wr_bank];
    assign drop   = bit_valid && full[wr_bank];
    assign fill   = (accept && (wr_idx == LAST_IDX)) ? (2'b01 << wr_bank) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= '0;
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            wr_idx   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            wr_idx   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            full <= (full & ~bank_free) | fill;
            if (accept) begin
                bank[wr_bank][wr_idx] <= bit_data;
                if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    pkt_byte_serializer #(
        .PACKET_BITS (PACKET_BITS),
        .BYTE_W      (BYTE_W)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bank_full  (full),
        .bank_fill  (fill),
        .bank_data  (bank),
        .bank_free  (bank_free),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .pkt_busy   (pkt_busy)
    );

endmodule
